h264_mb_scheduler: RTL and testbench

Frame-level macroblock scheduler for the H.264 encoder top. It walks a frame in raster order and issues one fetch per macroblock to the fetch unit, which loads 96 words (Y 16×16, U 8×8, V 8×8) into one of two ping-pong MB buffers. Once a buffer is filled, it hands that buffer to the encode datapath (prediction/transform). The fetch of MB n+1 overlaps the encode of MB n.

---
 rtl/h264_mb_scheduler_pkg.sv | 34 +++
 rtl/h264_mb_raster_cnt.sv | 41 ++++
 rtl/h264_mb_scheduler.sv | 153 +++++++++++++++
 tb/tb_h264_mb_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h264_mb_scheduler_pkg.sv
// Shared types for the H.264 macroblock scheduler: coordinate type, FSM state
// encodings and the debug snapshot exported by the scheduler top.
package h264_pkg;

    localparam int MB_COORD_W = 6;
    localparam int MB_WORDS   = 96;

    typedef logic [MB_COORD_W-1:0] mb_coord_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } sched_top_e;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT,
        F_BUSY,
        F_END
    } fetch_st_e;

    typedef enum logic {
        E_IDLE,
        E_BUSY
    } enc_st_e;

    typedef struct packed {
        sched_top_e top;
        fetch_st_e  fetch;
        enc_st_e    enc;
        logic [1:0] full;
    } sched_dbg_t;

endpackage

// File: rtl/h264_mb_raster_cnt.sv
// Raster-order macroblock coordinate counter; `last` flags the bottom-right MB
// of the frame described by width/height.
module h264_mb_raster_cnt #(
    parameter int MB_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    input  logic [MB_W-1:0] width,
    input  logic [MB_W-1:0] height,
    output logic [MB_W-1:0] x,
    output logic [MB_W-1:0] y,
    output logic            last
);

    localparam logic [MB_W-1:0] ONE = 1;

    logic x_end;

    assign x_end = (x == width - ONE);
    assign last  = x_end && (y == height - ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y + ONE;
            end else begin
                x <= x + ONE;
            end
        end
    end

endmodule

// File: rtl/h264_mb_scheduler.sv
// Frame-level MB scheduler: fetches MBs in raster order into two ping-pong
// buffers and hands each filled buffer to the encoder, overlapping the two.
module h264_mb_scheduler
    import h264_pkg::*;
#(
    parameter int MB_W = MB_COORD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [MB_W-1:0] frame_w_mb,
    input  logic [MB_W-1:0] frame_h_mb,
    output logic            fetch_start,
    output logic [MB_W-1:0] fetch_mb_x,
    output logic [MB_W-1:0] fetch_mb_y,
    output logic            fetch_buf_sel,
    input  logic            fetch_finish,
    output logic            enc_start,
    output logic [MB_W-1:0] enc_mb_x,
    output logic [MB_W-1:0] enc_mb_y,
    output logic            enc_buf_sel,
    input  logic            enc_done,
    output logic            busy,
    output logic            frame_done,
    output sched_dbg_t      dbg
);

    sched_top_e      top_q, top_n;
    fetch_st_e       fst_q, fst_n;
    enc_st_e         est_q, est_n;
    logic [1:0]      full_q, full_n;
    logic            fbuf_n, ebuf_n;
    logic [MB_W-1:0] w_q, h_q;
    logic            fetch_start_n, enc_start_n, busy_n, frame_done_n;
    logic            start_ok, ff_ok, ed_ok, frame_end;
    logic            fetch_last, enc_last, fetch_adv, enc_adv;

    assign start_ok  = (top_q == S_IDLE) && start && (frame_w_mb != '0) && (frame_h_mb != '0);
    assign ff_ok     = (fst_q == F_BUSY) && fetch_finish;
    assign ed_ok     = (est_q == E_BUSY) && enc_done;
    assign frame_end = ed_ok && enc_last;
    assign fetch_adv = ff_ok && !fetch_last;
    assign enc_adv   = ed_ok && !enc_last;

    h264_mb_raster_cnt #(.MB_W(MB_W)) u_fetch_cnt (
        .clk(clk), .rst(rst), .clear(start_ok), .advance(fetch_adv),
        .width(w_q), .height(h_q), .x(fetch_mb_x), .y(fetch_mb_y), .last(fetch_last)
    );

    h264_mb_raster_cnt #(.MB_W(MB_W)) u_enc_cnt (
        .clk(clk), .rst(rst), .clear(start_ok), .advance(enc_adv),
        .width(w_q), .height(h_q), .x(enc_mb_x), .y(enc_mb_y), .last(enc_last)
    );

    always_comb begin
        top_n         = top_q;
        fst_n         = fst_q;
        est_n         = est_q;
        full_n        = full_q;
        fbuf_n        = fetch_buf_sel ^ ff_ok;
        ebuf_n        = enc_buf_sel ^ ed_ok;
        fetch_start_n = 1'b0;
        enc_start_n   = 1'b0;
        frame_done_n  = frame_end;
        busy_n        = (top_q == S_RUN) && !frame_end;

        if (ff_ok) full_n[fetch_buf_sel] = 1'b1;
        if (ed_ok) full_n[enc_buf_sel]   = 1'b0;
        if (start_ok) begin
            fbuf_n = 1'b0;
            ebuf_n = 1'b0;
        end

        case (top_q)
            S_IDLE: if (start_ok) top_n = S_RUN;
            S_RUN:  if (frame_end) top_n = S_IDLE;
            default: top_n = S_IDLE;
        endcase

        // Decisions look at full_n so a same-edge release or fill is seen at once.
        case (fst_q)
            F_IDLE: if (start_ok) fst_n = F_WAIT;
            F_WAIT: begin
                if (!full_n[fbuf_n]) begin
                    fetch_start_n = 1'b1;
                    fst_n         = F_BUSY;
                end
            end
            F_BUSY: begin
                if (ff_ok) begin
                    if (fetch_last)          fst_n = F_END;
                    else if (!full_n[fbuf_n]) fetch_start_n = 1'b1;
                    else                      fst_n = F_WAIT;
                end
            end
            F_END:   fst_n = F_END;
            default: fst_n = F_IDLE;
        endcase
        if (frame_end) fst_n = F_IDLE;

        case (est_q)
            E_IDLE: begin
                if (full_n[ebuf_n]) begin
                    enc_start_n = 1'b1;
                    est_n       = E_BUSY;
                end
            end
            E_BUSY: begin
                if (ed_ok) begin
                    if (enc_last)            est_n = E_IDLE;
                    else if (full_n[ebuf_n]) enc_start_n = 1'b1;
                    else                     est_n = E_IDLE;
                end
            end
            default: est_n = E_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q         <= S_IDLE;
            fst_q         <= F_IDLE;
            est_q         <= E_IDLE;
            full_q        <= '0;
            fetch_buf_sel <= 1'b0;
            enc_buf_sel   <= 1'b0;
            w_q           <= '0;
            h_q           <= '0;
            fetch_start   <= 1'b0;
            enc_start     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            top_q         <= top_n;
            fst_q         <= fst_n;
            est_q         <= est_n;
            full_q        <= full_n;
            fetch_buf_sel <= fbuf_n;
            enc_buf_sel   <= ebuf_n;
            fetch_start   <= fetch_start_n;
            enc_start     <= enc_start_n;
            busy          <= busy_n;
            frame_done    <= frame_done_n;
            if (start_ok) begin
                w_q <= frame_w_mb;
                h_q <= frame_h_mb;
            end
        end
    end

    assign dbg = '{top: top_q, fetch: fst_q, enc: est_q, full: full_q};

endmodule

// File: tb/tb_h264_mb_scheduler.sv
// Directed bench for h264_mb_scheduler: manual and auto-responding fetch/encode
// agents, a negedge monitor logging every start pulse, and an expected queue.
module tb_h264_mb_scheduler;
    import h264_pkg::*;

    localparam int W  = 6;
    localparam int LW = 2 * W + 1;

    logic         clk, rst, start;
    logic [W-1:0] frame_w_mb, frame_h_mb;
    logic         fetch_start, fetch_buf_sel, fetch_finish;
    logic [W-1:0] fetch_mb_x, fetch_mb_y, enc_mb_x, enc_mb_y;
    logic         enc_start, enc_buf_sel, enc_done, busy, frame_done;
    sched_dbg_t   dbg;

    logic f_man = 1'b0, e_man = 1'b0, f_auto = 1'b0, e_auto = 1'b0;
    assign fetch_finish = f_man | f_auto;
    assign enc_done     = e_man | e_auto;

    int n_checks = 0, n_pass = 0, n_fail = 0;
    int cyc = 0;
    logic [LW-1:0] fs_log[$], es_log[$], exp_q[$];
    int  fs_cyc[$], ed_cyc[$];
    int  n_fd = 0, n_fs = 0, n_ed = 0;
    bit  auto_fetch = 0, auto_enc = 0, track = 0;
    int  enc_lat = 0, fs_base = 0, ed_base = 0, max_ahead = 0;

    h264_mb_scheduler #(.MB_W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .frame_w_mb(frame_w_mb), .frame_h_mb(frame_h_mb),
        .fetch_start(fetch_start), .fetch_mb_x(fetch_mb_x), .fetch_mb_y(fetch_mb_y),
        .fetch_buf_sel(fetch_buf_sel), .fetch_finish(fetch_finish),
        .enc_start(enc_start), .enc_mb_x(enc_mb_x), .enc_mb_y(enc_mb_y),
        .enc_buf_sel(enc_buf_sel), .enc_done(enc_done),
        .busy(busy), .frame_done(frame_done), .dbg(dbg)
    );

    // clock / cycle counter / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // auto responders: act at negedge so inputs are stable at the next posedge
    initial forever begin
        @(negedge clk);
        f_auto = auto_fetch && fetch_start;
    end

    initial begin : enc_responder
        bit pend;
        int remain;
        pend = 0;
        remain = 0;
        forever begin
            @(negedge clk);
            e_auto = 1'b0;
            if (auto_enc && enc_start) begin
                pend   = 1;
                remain = enc_lat;
            end
            if (pend) begin
                if (remain == 0) begin
                    e_auto = 1'b1;
                    pend   = 0;
                end else begin
                    remain--;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        if (fetch_start) begin
            fs_log.push_back({fetch_mb_x, fetch_mb_y, fetch_buf_sel});
            fs_cyc.push_back(cyc);
            n_fs++;
        end
        if (enc_start) es_log.push_back({enc_mb_x, enc_mb_y, enc_buf_sel});
        if (enc_done) begin
            ed_cyc.push_back(cyc);
            n_ed++;
        end
        if (frame_done) n_fd++;
        if (!track) max_ahead = 0;
        else if ((n_fs - fs_base) - (n_ed - ed_base) > max_ahead)
            max_ahead = (n_fs - fs_base) - (n_ed - ed_base);
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int w, input int h);
        frame_w_mb = W'(w);
        frame_h_mb = W'(h);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag, input int budget);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_frame_done"}, 32'(frame_done), 1);
        check({tag, "_busy_low"}, 32'(busy), 0);
        check({tag, "_top_idle"}, 32'(dbg.top), 32'(S_IDLE));
    endtask

    function automatic logic [LW-1:0] ent(input int x, input int y, input int b);
        return {W'(x), W'(y), 1'(b)};
    endfunction

    initial begin : stim
        int fb, eb, edb, fd0;

        rst = 1'b0;
        start = 1'b0;
        frame_w_mb = '0;
        frame_h_mb = '0;
        repeat (3) step();
        check("reset_outputs", 32'({fetch_start, enc_start, busy, frame_done, fetch_buf_sel,
              enc_buf_sel, fetch_mb_x, fetch_mb_y, enc_mb_x, enc_mb_y}), 0);
        check("reset_dbg", 32'(dbg), 0);
        rst = 1'b1;
        step();

        // 1x1 frame, manual responses with exact latencies
        start_frame(1, 1);
        check("1x1_accept_cycle", 32'({busy, fetch_start}), 0);
        step();
        check("1x1_fetch_pulse", 32'({busy, fetch_start}), 2'b11);
        check("1x1_fetch_coord", 32'({fetch_mb_x, fetch_mb_y, fetch_buf_sel}), 32'(ent(0, 0, 0)));
        f_man = 1'b1;
        step();
        f_man = 1'b0;
        check("1x1_enc_pulse", 32'({enc_start, fetch_start, enc_buf_sel}), 3'b100);
        check("1x1_full_state", 32'({dbg.fetch, dbg.full}), 32'({F_END, 2'b01}));
        e_man = 1'b1;
        step();
        e_man = 1'b0;
        check("1x1_done", 32'({frame_done, busy, enc_start}), 3'b100);
        check("1x1_top_idle", 32'(dbg.top), 32'(S_IDLE));
        step();
        check("1x1_done_one_cycle", 32'(frame_done), 0);

        // zero dimension starts are ignored
        fb = fs_log.size();
        start_frame(0, 2);
        repeat (3) step();
        start_frame(3, 0);
        repeat (5) step();
        check("zero_dim_busy", 32'(busy), 0);
        check("zero_dim_top", 32'(dbg.top), 32'(S_IDLE));
        check("zero_dim_no_fetch", 32'(fs_log.size() - fb), 0);

        // 3x2 frame, instant responders
        fb = fs_log.size();
        eb = es_log.size();
        fd0 = n_fd;
        auto_fetch = 1;
        auto_enc = 1;
        enc_lat = 0;
        start_frame(3, 2);
        wait_frame_done("3x2", 200);
        repeat (3) step();
        auto_fetch = 0;
        auto_enc = 0;
        check("3x2_fetch_count", 32'(fs_log.size() - fb), 6);
        check("3x2_enc_count", 32'(es_log.size() - eb), 6);
        check("3x2_frame_done_count", 32'(n_fd - fd0), 1);
        exp_q.push_back(ent(0, 0, 0));
        exp_q.push_back(ent(1, 0, 1));
        exp_q.push_back(ent(2, 0, 0));
        exp_q.push_back(ent(0, 1, 1));
        exp_q.push_back(ent(1, 1, 0));
        exp_q.push_back(ent(2, 1, 1));
        for (int i = 0; i < 6; i++) begin
            logic [LW-1:0] e;
            e = exp_q.pop_front();
            if (fb + i < fs_log.size()) check($sformatf("3x2_fetch_%0d", i), 32'(fs_log[fb + i]), 32'(e));
            if (eb + i < es_log.size()) check($sformatf("3x2_enc_%0d", i), 32'(es_log[eb + i]), 32'(e));
        end
        repeat ($urandom_range(2, 6)) step();

        // 4x1 frame, slow encoder; stray fetch_finish and start while running
        fb = fs_log.size();
        eb = es_log.size();
        edb = ed_cyc.size();
        fs_base = n_fs;
        ed_base = n_ed;
        track = 1;
        auto_fetch = 1;
        auto_enc = 1;
        enc_lat = 200;
        start_frame(4, 1);
        repeat ($urandom_range(10, 40)) step();
        check("slow_stall_state", 32'({dbg.fetch, dbg.full}), 32'({F_WAIT, 2'b11}));
        f_man = 1'b1;
        step();
        f_man = 1'b0;
        step();
        check("stray_ff_ignored", 32'({dbg.fetch, dbg.full, fetch_buf_sel, fetch_mb_x}),
              32'({F_WAIT, 2'b11, 1'b0, 6'd2}));
        start_frame(1, 1);
        step();
        check("start_in_run_ignored", 32'({busy, dbg.top, fetch_mb_x}), 32'({1'b1, S_RUN, 6'd2}));
        wait_frame_done("slow", 2000);
        repeat (2) step();
        track = 0;
        auto_fetch = 0;
        auto_enc = 0;
        check("slow_fetch_count", 32'(fs_log.size() - fb), 4);
        check("slow_enc_count", 32'(es_log.size() - eb), 4);
        exp_q.push_back(ent(0, 0, 0));
        exp_q.push_back(ent(1, 0, 1));
        exp_q.push_back(ent(2, 0, 0));
        exp_q.push_back(ent(3, 0, 1));
        for (int i = 0; i < 4; i++) begin
            logic [LW-1:0] e;
            e = exp_q.pop_front();
            if (fb + i < fs_log.size()) check($sformatf("slow_fetch_%0d", i), 32'(fs_log[fb + i]), 32'(e));
        end
        if (fs_log.size() > fb + 2 && ed_cyc.size() > edb)
            check("slow_third_fetch_latency", 32'(fs_cyc[fb + 2] - ed_cyc[edb]), 1);
        else
            check("slow_third_fetch_present", 32'(fs_log.size() - fb), 4);
        check("slow_max_ahead", 32'(max_ahead), 2);

        // simultaneous fetch_finish and enc_done on a 3x1 frame
        eb = es_log.size();
        start_frame(3, 1);
        step();
        check("sim_first_fetch", 32'({fetch_start, fetch_mb_x, fetch_buf_sel}), 32'({1'b1, 6'd0, 1'b0}));
        f_man = 1'b1;
        step();
        f_man = 1'b0;
        check("sim_pair1", 32'({fetch_start, fetch_mb_x, fetch_buf_sel, enc_start, enc_mb_x, enc_buf_sel}),
              32'({1'b1, 6'd1, 1'b1, 1'b1, 6'd0, 1'b0}));
        f_man = 1'b1;
        e_man = 1'b1;
        step();
        f_man = 1'b0;
        e_man = 1'b0;
        check("sim_pair2", 32'({fetch_start, fetch_mb_x, fetch_buf_sel, enc_start, enc_mb_x, enc_buf_sel}),
              32'({1'b1, 6'd2, 1'b0, 1'b1, 6'd1, 1'b1}));
        auto_fetch = 1;
        auto_enc = 1;
        enc_lat = 0;
        wait_frame_done("sim", 100);
        repeat (2) step();
        auto_fetch = 0;
        auto_enc = 0;
        check("sim_enc_count", 32'(es_log.size() - eb), 3);

        // asynchronous reset in the middle of the (1,0) fetch
        start_frame(3, 1);
        step();
        f_man = 1'b1;
        step();
        f_man = 1'b0;
        check("rst_pre_fetch10", 32'({fetch_start, fetch_mb_x, fetch_buf_sel}), 32'({1'b1, 6'd1, 1'b1}));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_outputs", 32'({fetch_start, enc_start, busy, frame_done, fetch_buf_sel,
              enc_buf_sel, fetch_mb_x, fetch_mb_y, enc_mb_x, enc_mb_y}), 0);
        check("rst_async_dbg", 32'(dbg), 0);
        step();
        rst = 1'b1;
        step();
        start_frame(2, 1);
        step();
        check("rst_restart", 32'({busy, fetch_start, fetch_mb_x, fetch_mb_y, fetch_buf_sel}),
              32'({2'b11, ent(0, 0, 0)}));
        auto_fetch = 1;
        auto_enc = 1;
        wait_frame_done("restart", 100);
        auto_fetch = 0;
        auto_enc = 0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
